// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bus between NREQ requesters and the register-file write-port arbiter.
// The master drives requests; the slave (arbiter) returns ready, the write port and status.
interface regfile_wb_arbiter_if #(
   parameter int NREQ = 3
);
   logic [NREQ-1:0]    req_valid;
   logic [NREQ*5-1:0]  req_rd;
   logic [NREQ*64-1:0] req_data;
   logic [NREQ-1:0]    req_ready;
   logic               reg_write;
   logic [4:0]         rd;
   logic [63:0]        write_data;
   logic [31:0]        pending_mask;
   logic [NREQ-1:0]    starve;

   modport master (
      output req_valid, req_rd, req_data,
      input  req_ready, reg_write, rd, write_data, pending_mask, starve
   );

   modport slave (
      input  req_valid, req_rd, req_data,
      output req_ready, reg_write, rd, write_data, pending_mask, starve
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file's single write port among NREQ writeback
// requesters, with a registered write port, starvation flags and a pending-destination mask.
module regfile_wb_arbiter #(
   parameter int NREQ         = 3,
   parameter int STARVE_LIMIT = 15
) (
   input  logic                 clk,
   input  logic                 reset,
   regfile_wb_arbiter_if.slave  bus
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

   logic [4:0]      rd_of   [NREQ];
   logic [63:0]     data_of [NREQ];
   logic [NREQ-1:0] cand;
   logic [NREQ-1:0] zero_rd;
   logic [NREQ-1:0] ready;
   logic [31:0]     pending;

   logic [PW-1:0]   ptr_q, ptr_d;
   logic            win_found;
   logic [PW-1:0]   win_idx;
   logic            grant;

   logic            reg_write_q, reg_write_d;
   logic [4:0]      rd_q, rd_d;
   logic [63:0]     wdata_q, wdata_d;

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
         assign rd_of[gi]   = bus.req_rd[gi*5 +: 5];
         assign data_of[gi] = bus.req_data[gi*64 +: 64];
         assign cand[gi]    = bus.req_valid[gi] && (rd_of[gi] != 5'd0);
         assign zero_rd[gi] = bus.req_valid[gi] && (rd_of[gi] == 5'd0);
      end
   endgenerate

   // First real write request found scanning ptr, ptr+1, ... modulo NREQ.
   always_comb begin
      logic [PW:0] sum;
      win_found = 1'b0;
      win_idx   = '0;
      sum       = '0;
      for (int k = 0; k < NREQ; k++) begin
         sum = {1'b0, ptr_q} + (PW+1)'(k);
         if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
         if (!win_found && cand[sum[PW-1:0]]) begin
            win_found = 1'b1;
            win_idx   = sum[PW-1:0];
         end
      end
   end

   assign grant = win_found && !reset;

   // rd==0 requests are drained immediately without taking the write slot.
   always_comb begin
      ready = '0;
      if (!reset) begin
         ready = zero_rd;
         if (win_found) ready[win_idx] = 1'b1;
      end
   end

   always_comb begin
      pending = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (cand[i] && !ready[i]) pending[rd_of[i]] = 1'b1;
      end
   end

   always_comb begin
      ptr_d       = ptr_q;
      reg_write_d = 1'b0;
      rd_d        = rd_q;
      wdata_d     = wdata_q;
      if (grant) begin
         ptr_d       = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + PW'(1);
         reg_write_d = 1'b1;
         rd_d        = rd_of[win_idx];
         wdata_d     = data_of[win_idx];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q       <= '0;
         reg_write_q <= 1'b0;
         rd_q        <= '0;
         wdata_q     <= '0;
      end else begin
         ptr_q       <= ptr_d;
         reg_write_q <= reg_write_d;
         rd_q        <= rd_d;
         wdata_q     <= wdata_d;
      end
   end

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_wait
         logic [CW-1:0] cnt_q, cnt_d;
         logic          starve_q, starve_d;

         always_comb begin
            cnt_d = cnt_q;
            if (!bus.req_valid[gi] || ready[gi]) cnt_d = '0;
            else if (cnt_q != LIMIT)             cnt_d = cnt_q + CW'(1);
            starve_d = starve_q || (cnt_d == LIMIT);
         end

         always_ff @(posedge clk) begin
            if (reset) begin
               cnt_q    <= '0;
               starve_q <= 1'b0;
            end else begin
               cnt_q    <= cnt_d;
               starve_q <= starve_d;
            end
         end

         assign bus.starve[gi] = starve_q;
      end
   endgenerate

   assign bus.req_ready    = ready;
   assign bus.pending_mask = pending;
   assign bus.reg_write    = reg_write_q;
   assign bus.rd           = rd_q;
   assign bus.write_data   = wdata_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios with literal expectations, then randomized
// traffic checked every cycle against a queue-free behavioural model of the arbitration rules.
module tb_regfile_wb_arbiter;
   localparam int N   = 3;
   localparam int LIM = 15;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst  = 1'b1;
   logic rst2 = 1'b1;

   regfile_wb_arbiter_if #(.NREQ(N)) bus ();
   regfile_wb_arbiter_if #(.NREQ(3)) bus2 ();

   regfile_wb_arbiter #(.NREQ(N), .STARVE_LIMIT(LIM)) dut (
      .clk   (clk),
      .reset (rst),
      .bus   (bus)
   );

   // Small second instance whose low limit lets ordinary round-robin waiting reach starvation.
   regfile_wb_arbiter #(.NREQ(3), .STARVE_LIMIT(2)) dut2 (
      .clk   (clk),
      .reset (rst2),
      .bus   (bus2)
   );

   int unsigned vectors     = 0;
   int unsigned miscompares = 0;

   bit          v [N];
   logic [4:0]  r [N];
   logic [63:0] d [N];

   int          m_ptr = 0;
   bit          m_we  = 1'b0;
   logic [4:0]  m_rd  = '0;
   logic [63:0] m_wd  = '0;
   int          m_cnt    [N];
   bit          m_starve [N];
   int          m_win;
   logic [N-1:0] m_ready;
   logic [31:0]  m_pend;
   logic [N-1:0] dut_ready;
   logic [31:0]  dut_pend;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock: drive requests, check combinational outputs, advance model, check registers.
   task automatic step();
      logic [N-1:0] ms;
      for (int i = 0; i < N; i++) begin
         bus.req_valid[i]          = v[i];
         bus.req_rd[i*5 +: 5]      = r[i];
         bus.req_data[i*64 +: 64]  = d[i];
      end
      #1;
      m_win = -1;
      for (int k = 0; k < N; k++) begin
         int idx = (m_ptr + k) % N;
         if (m_win < 0 && v[idx] && r[idx] != 5'd0) m_win = idx;
      end
      m_ready = '0;
      m_pend  = '0;
      if (!rst) begin
         for (int i = 0; i < N; i++)
            if (v[i] && (r[i] == 5'd0 || i == m_win)) m_ready[i] = 1'b1;
      end
      for (int i = 0; i < N; i++)
         if (v[i] && !m_ready[i] && r[i] != 5'd0) m_pend[r[i]] = 1'b1;
      dut_ready = bus.req_ready;
      dut_pend  = bus.pending_mask;
      chk("req_ready", 64'(dut_ready), 64'(m_ready));
      chk("pending_mask", 64'(dut_pend), 64'(m_pend));
      @(posedge clk);
      if (rst) begin
         m_ptr = 0; m_we = 1'b0; m_rd = '0; m_wd = '0;
         for (int i = 0; i < N; i++) begin m_cnt[i] = 0; m_starve[i] = 1'b0; end
      end else begin
         if (m_win >= 0) begin
            m_we = 1'b1; m_rd = r[m_win]; m_wd = d[m_win]; m_ptr = (m_win + 1) % N;
         end else begin
            m_we = 1'b0;
         end
         for (int i = 0; i < N; i++) begin
            if (!v[i] || m_ready[i]) m_cnt[i] = 0;
            else if (m_cnt[i] < LIM) m_cnt[i]++;
            if (m_cnt[i] == LIM) m_starve[i] = 1'b1;
         end
      end
      @(negedge clk);
      for (int i = 0; i < N; i++) ms[i] = m_starve[i];
      chk("reg_write", 64'(bus.reg_write), 64'(m_we));
      chk("rd", 64'(bus.rd), 64'(m_rd));
      chk("write_data", bus.write_data, m_wd);
      chk("starve", 64'(bus.starve), 64'(ms));
      for (int i = 0; i < N; i++) if (m_ready[i]) v[i] = 1'b0;
      vectors++;
   endtask

   task automatic clear_reqs();
      for (int i = 0; i < N; i++) begin v[i] = 1'b0; r[i] = '0; d[i] = '0; end
   endtask

   task automatic step2();
      @(posedge clk);
      @(negedge clk);
      vectors++;
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin m_cnt[i] = 0; m_starve[i] = 1'b0; end
      bus2.req_valid = '0;
      bus2.req_rd    = '0;
      bus2.req_data  = '0;
      clear_reqs();

      // Reset held with all requesters valid: nothing consumed, outputs cleared.
      rst = 1'b1;
      for (int i = 0; i < N; i++) begin v[i] = 1'b1; r[i] = 5'(5 + i); d[i] = 64'(10 + i); end
      for (int c = 0; c < 3; c++) begin
         step();
         chk("t1_ready", 64'(dut_ready), 64'd0);
         chk("t1_reg_write", 64'(bus.reg_write), 64'd0);
         chk("t1_rd", 64'(bus.rd), 64'd0);
         chk("t1_write_data", bus.write_data, 64'd0);
      end

      // Continuous contention: grants rotate 0,1,2,0,...
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         for (int i = 0; i < N; i++) begin v[i] = 1'b1; r[i] = 5'(5 + i); d[i] = 64'(10 + i); end
         step();
         chk("t2_grant", 64'(dut_ready), 64'(1) << (k % 3));
         chk("t2_reg_write", 64'(bus.reg_write), 64'd1);
         chk("t2_rd", 64'(bus.rd), 64'(5 + k % 3));
         chk("t2_write_data", bus.write_data, 64'(10 + k % 3));
      end

      // Lone requester 2, then idle: rd holds.
      clear_reqs();
      v[2] = 1'b1; r[2] = 5'd9; d[2] = 64'h1234;
      step();
      chk("t3_ready", 64'(dut_ready), 64'b100);
      chk("t3_rd", 64'(bus.rd), 64'd9);
      chk("t3_write_data", bus.write_data, 64'h1234);
      step();
      chk("t3_idle_reg_write", 64'(bus.reg_write), 64'd0);
      chk("t3_idle_rd", 64'(bus.rd), 64'd9);

      // rd==0 alongside a real write: both ready, one write.
      v[0] = 1'b1; r[0] = 5'd0; d[0] = 64'h55;
      v[1] = 1'b1; r[1] = 5'd4; d[1] = 64'h44;
      step();
      chk("t4_ready", 64'(dut_ready), 64'b011);
      chk("t4_rd", 64'(bus.rd), 64'd4);
      step();
      chk("t4_single_write", 64'(bus.reg_write), 64'd0);

      // ptr should now be 2: requester 2 beats requester 0, then 0 is served (ptr -> 1).
      v[0] = 1'b1; r[0] = 5'd1; d[0] = 64'h01;
      v[2] = 1'b1; r[2] = 5'd2; d[2] = 64'h02;
      step();
      chk("t4_ptr2", 64'(dut_ready), 64'b100);
      step();
      chk("t4_ptr0", 64'(dut_ready), 64'b001);

      // Same rd from two requesters with ptr=1: 0x22 then 0x11.
      v[0] = 1'b1; r[0] = 5'd3; d[0] = 64'h11;
      v[1] = 1'b1; r[1] = 5'd3; d[1] = 64'h22;
      step();
      chk("t5_ready", 64'(dut_ready), 64'b010);
      chk("t5_pending", 64'(dut_pend), 64'h8);
      chk("t5_data1", bus.write_data, 64'h22);
      step();
      chk("t5_ready2", 64'(dut_ready), 64'b001);
      chk("t5_pending2", 64'(dut_pend), 64'h0);
      chk("t5_data2", bus.write_data, 64'h11);
      chk("t5_rd2", 64'(bus.rd), 64'd3);

      // Randomized traffic with occasional mid-stream resets.
      for (int c = 0; c < 3000; c++) begin
         rst = ($urandom_range(0, 99) == 0);
         for (int i = 0; i < N; i++) begin
            if (!v[i] && $urandom_range(0, 3) != 0) begin
               v[i] = 1'b1;
               r[i] = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 7));
               d[i] = {$urandom, $urandom};
            end
         end
         step();
      end
      rst = 1'b0;
      clear_reqs();
      step();

      // Starvation on the limit-2 instance: requester 2 waits two cycles.
      bus2.req_valid = 3'b111;
      bus2.req_rd    = {5'd3, 5'd2, 5'd1};
      bus2.req_data  = {64'h3, 64'h2, 64'h1};
      rst2 = 1'b0;
      #1;
      chk("t6_ready_c0", 64'(bus2.req_ready), 64'b001);
      chk("t6_starve_c0", 64'(bus2.starve), 64'd0);
      step2();
      chk("t6_starve_c1", 64'(bus2.starve), 64'd0);
      bus2.req_valid = 3'b110;
      #1;
      chk("t6_ready_c1", 64'(bus2.req_ready), 64'b010);
      step2();
      chk("t6_starve_set", 64'(bus2.starve), 64'b100);
      bus2.req_valid = 3'b100;
      #1;
      chk("t6_ready_c2", 64'(bus2.req_ready), 64'b100);
      step2();
      bus2.req_valid = 3'b000;
      step2();
      step2();
      chk("t6_starve_sticky", 64'(bus2.starve), 64'b100);
      rst2 = 1'b1;
      step2();
      chk("t6_starve_reset", 64'(bus2.starve), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
